sw_led_sequencer: RTL

Front-panel controller between the four active-low push switches and the four board LEDs. It synchronises and debounces every switch and turns presses into single-cycle events. A mode state machine uses those events to drive the LEDs as off, static, blinking or chasing patterns, with speed, pause and lamp-test controls. It replaces ad-hoc per-switch edge/toggle logic at the top level.

---
 rtl/sw_led_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sw_led_sequencer.sv
// Front-panel controller: debounced active-low switches drive an OFF/STATIC/BLINK/CHASE LED sequencer.
// LEDs and o_mode are registered one cycle after a press event or step; CHASE is compiled in with SW_LED_SEQ_CHASE_EN.
module sw_led_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TICK_DIV        = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_sw_n,
  output logic       o_led_blue,
  output logic       o_led_green,
  output logic       o_led_orange,
  output logic       o_led_red,
  output logic [1:0] o_mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TK_W = $clog2(2 * TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] FAST_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [TK_W-1:0] SLOW_LAST = TK_W'(2 * TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  logic [3:0]      sync_q1, sync_q2, deb_lvl, deb_prev;
  logic [DB_W-1:0] deb_cnt [4];
  logic [3:0]      press_evt;
  logic            lamp_test;

  // Sync flops reset to "released" so reset exit never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q1  <= '1;
      sync_q2  <= '1;
      deb_lvl  <= '1;
      deb_prev <= '1;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync_q1  <= i_sw_n;
      sync_q2  <= sync_q1;
      deb_prev <= deb_lvl;
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DB_LAST) begin
          deb_lvl[i] <= sync_q2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press_evt = deb_prev & ~deb_lvl;
  assign lamp_test = ~deb_lvl[3];

  mode_e           mode_q, mode_adv, mode_nxt;
  logic            speed_slow_q, paused_q, blink_on_q, blink_nxt;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_nxt, period_last;
  logic            step, mode_chg, speed_chg;
  logic [3:0]      pattern, led_q;
`ifdef SW_LED_SEQ_CHASE_EN
  logic [3:0]      chase_q, chase_nxt;
`endif

  always_comb begin
    mode_chg    = press_evt[0];
    speed_chg   = press_evt[1];
    period_last = speed_slow_q ? SLOW_LAST : FAST_LAST;
    step        = ~paused_q && (tick_cnt_q == period_last);

    case (mode_q)
      MODE_OFF:    mode_adv = MODE_STATIC;
      MODE_STATIC: mode_adv = MODE_BLINK;
`ifdef SW_LED_SEQ_CHASE_EN
      MODE_BLINK:  mode_adv = MODE_CHASE;
`else
      MODE_BLINK:  mode_adv = MODE_OFF;
`endif
      default:     mode_adv = MODE_OFF;
    endcase
    mode_nxt = mode_chg ? mode_adv : mode_q;

    // A mode change restarts the pattern and swallows any coincident step.
    blink_nxt = blink_on_q;
    if (mode_chg)                         blink_nxt = 1'b1;
    else if (step && mode_q == MODE_BLINK) blink_nxt = ~blink_on_q;

`ifdef SW_LED_SEQ_CHASE_EN
    chase_nxt = chase_q;
    if (mode_chg)                         chase_nxt = 4'b0001;
    else if (step && mode_q == MODE_CHASE) chase_nxt = {chase_q[2:0], chase_q[3]};
`endif

    tick_cnt_nxt = tick_cnt_q;
    if (mode_chg || speed_chg) tick_cnt_nxt = '0;
    else if (paused_q)         tick_cnt_nxt = tick_cnt_q;
    else if (step)             tick_cnt_nxt = '0;
    else                       tick_cnt_nxt = tick_cnt_q + 1'b1;

    case (mode_nxt)
      MODE_STATIC: pattern = 4'b1111;
      MODE_BLINK:  pattern = {4{blink_nxt}};
`ifdef SW_LED_SEQ_CHASE_EN
      MODE_CHASE:  pattern = chase_nxt;
`endif
      default:     pattern = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q       <= MODE_OFF;
      speed_slow_q <= 1'b0;
      paused_q     <= 1'b0;
      blink_on_q   <= 1'b1;
      tick_cnt_q   <= '0;
      led_q        <= 4'b0000;
`ifdef SW_LED_SEQ_CHASE_EN
      chase_q      <= 4'b0001;
`endif
    end else begin
      mode_q       <= mode_nxt;
      speed_slow_q <= speed_slow_q ^ speed_chg;
      paused_q     <= paused_q ^ press_evt[2];
      blink_on_q   <= blink_nxt;
      tick_cnt_q   <= tick_cnt_nxt;
      led_q        <= lamp_test ? 4'b1111 : pattern;
`ifdef SW_LED_SEQ_CHASE_EN
      chase_q      <= chase_nxt;
`endif
    end
  end

  assign o_led_blue   = led_q[0];
  assign o_led_green  = led_q[1];
  assign o_led_orange = led_q[2];
  assign o_led_red    = led_q[3];
  assign o_mode       = mode_q;

endmodule
